// File: rtl/data_memory_mc.sv
// rtl/data_memory_mc.sv - multi-cycle byte-addressed little-endian data memory
// Valid/ready request, LATENCY-cycle response pulse, encoded exception cause.
module data_memory_mc #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        memWrite,
  input  logic        memRead,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  output logic        respValid,
  output logic [31:0] dout,
  output logic        exception,
  output logic [1:0]  excCause
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, r_din;
  logic        r_write, r_read, r_sign;
  logic [1:0]  r_size, r_cause;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept, w_enter_resp_ok, w_wr_en, w_oor;
  logic [31:0] w_addr, w_din;
  logic        w_write, w_read, w_sign;
  logic [1:0]  w_size, w_cause;
  logic [32:0] w_diff;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rdata, w_merged, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // In IDLE the live inputs are the request; afterwards the latched copy is.
  assign w_accept = (r_state == IDLE) && reqValid;
  assign w_addr   = (r_state == IDLE) ? addr     : r_addr;
  assign w_din    = (r_state == IDLE) ? din      : r_din;
  assign w_write  = (r_state == IDLE) ? memWrite : r_write;
  assign w_read   = (r_state == IDLE) ? memRead  : r_read;
  assign w_size   = (r_state == IDLE) ? memSize  : r_size;
  assign w_sign   = (r_state == IDLE) ? memSign  : r_sign;

  // Borrow lands in bit 30 after the shift, so below-base addresses compare as huge.
  assign w_diff = ({1'b0, w_addr} - {1'b0, BASE_ADDR}) >> 2;
  assign w_oor  = (w_diff >= 33'(DEPTH_WORDS));
  assign w_idx  = w_diff[AW-1:0];

  always_comb begin
    w_cause = 2'b00;
    if (w_read && w_write)
      w_cause = 2'b11;
    else if (w_size == 2'b11)
      w_cause = 2'b11;
    else if ((w_size == 2'b01 && w_addr[0]) || (w_size == 2'b10 && w_addr[1:0] != 2'b00))
      w_cause = 2'b01;
    else if (w_oor)
      w_cause = 2'b10;
  end

  assign w_enter_resp_ok = (w_accept && w_cause == 2'b00 && LATENCY == 1) ||
                           (r_state == BUSY && r_cnt == 4'd1);
  assign w_wr_en = w_enter_resp_ok && w_write && !rst;

  assign w_rdata = r_mem[w_idx];
  assign w_byte  = w_rdata[{w_addr[1:0], 3'b000} +: 8];
  assign w_half  = w_addr[1] ? w_rdata[31:16] : w_rdata[15:0];

  always_comb begin
    w_load = w_rdata;
    case (w_size)
      2'b00:   w_load = {{24{w_sign & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{w_sign & w_half[15]}}, w_half};
      default: w_load = w_rdata;
    endcase
  end

  always_comb begin
    w_merged = w_rdata;
    case (w_size)
      2'b00:   w_merged[{w_addr[1:0], 3'b000} +: 8] = w_din[7:0];
      2'b01:   w_merged[{w_addr[1], 4'b0000} +: 16] = w_din[15:0];
      default: w_merged = w_din;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (reqValid) begin
          if (w_cause != 2'b00 || LATENCY == 1) begin
            w_state_nxt = RESP;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'h0;
      r_din   <= 32'h0;
      r_write <= 1'b0;
      r_read  <= 1'b0;
      r_size  <= 2'b00;
      r_sign  <= 1'b0;
      r_cause <= 2'b00;
      dout    <= 32'h0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr;
        r_din   <= din;
        r_write <= memWrite;
        r_read  <= memRead;
        r_size  <= memSize;
        r_sign  <= memSign;
        r_cause <= w_cause;
      end
      // Stores leave dout alone; NOPs return zero.
      if (w_enter_resp_ok && !w_write)
        dout <= w_read ? w_load : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_idx] <= w_merged;
  end

  assign reqReady  = (r_state == IDLE);
  assign respValid = (r_state == RESP);
  assign exception = (r_state == RESP) && (r_cause != 2'b00);
  assign excCause  = (r_state == RESP) ? r_cause : 2'b00;

endmodule

// File: tb/tb_data_memory_mc.sv
// tb/tb_data_memory_mc.sv - scoreboard bench for data_memory_mc
// Three instances: LATENCY 2 / base 0, LATENCY 1 / base 0x1000, LATENCY 4 / base 0.
module tb_data_memory_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, reqValid, reqReady, memWrite, memRead, memSign, respValid, exception;
  logic [31:0] addr [3];
  logic [31:0] din  [3];
  logic [31:0] dout [3];
  logic [1:0]  memSize  [3];
  logic [1:0]  excCause [3];

  data_memory_mc #(.DEPTH_WORDS(16), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .rst(rst[0]), .reqValid(reqValid[0]), .reqReady(reqReady[0]),
    .addr(addr[0]), .din(din[0]), .memWrite(memWrite[0]), .memRead(memRead[0]),
    .memSize(memSize[0]), .memSign(memSign[0]), .respValid(respValid[0]),
    .dout(dout[0]), .exception(exception[0]), .excCause(excCause[0]));
  data_memory_mc #(.DEPTH_WORDS(16), .LATENCY(1), .BASE_ADDR(32'h0000_1000)) u1 (
    .clk(clk), .rst(rst[1]), .reqValid(reqValid[1]), .reqReady(reqReady[1]),
    .addr(addr[1]), .din(din[1]), .memWrite(memWrite[1]), .memRead(memRead[1]),
    .memSize(memSize[1]), .memSign(memSign[1]), .respValid(respValid[1]),
    .dout(dout[1]), .exception(exception[1]), .excCause(excCause[1]));
  data_memory_mc #(.DEPTH_WORDS(16), .LATENCY(4), .BASE_ADDR(32'h0000_0000)) u2 (
    .clk(clk), .rst(rst[2]), .reqValid(reqValid[2]), .reqReady(reqReady[2]),
    .addr(addr[2]), .din(din[2]), .memWrite(memWrite[2]), .memRead(memRead[2]),
    .memSize(memSize[2]), .memSign(memSign[2]), .respValid(respValid[2]),
    .dout(dout[2]), .exception(exception[2]), .excCause(excCause[2]));

  typedef struct {
    int          due;
    logic        exc;
    logic [1:0]  cause;
    logic        st;
    logic        keep;
    logic        chk;
    logic [31:0] dv;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
  } exp_t;

  exp_t        q [3][$];
  exp_t        mon_e;
  logic [7:0]  ref_mem [longint];
  logic [31:0] last_dout [3];
  bit          last_known [3];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 1) ? 32'h0000_1000 : 32'h0000_0000;
  endfunction

  function automatic longint key_of(input int k, input logic [31:0] a);
    return (longint'(k) << 32) | longint'(a);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [1:0] cause_of(input int k, input logic rd, input logic wr,
                                          input logic [1:0] sz, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_of(k));
    if (rd && wr) return 2'b11;
    if (sz == 2'b11) return 2'b11;
    if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)) return 2'b01;
    if (off < 0 || off >= 64) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit load_val(input int k, input logic [31:0] a, input logic [1:0] sz,
                                  input logic sg, output logic [31:0] v);
    int n;
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      if (!ref_mem.exists(key_of(k, a + 32'(i)))) return 1'b0;
      v[8*i +: 8] = ref_mem[key_of(k, a + 32'(i))];
    end
    if (sg && n < 4 && v[8*n-1])
      for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Must be called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int k, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit use_lit, input logic [31:0] lit,
                       output int acc);
    exp_t e;
    int w;
    logic [31:0] v;
    addr[k] = a; din[k] = d; memRead[k] = rd; memWrite[k] = wr;
    memSize[k] = sz; memSign[k] = sg; reqValid[k] = 1'b1;
    w = 0;
    while (!reqReady[k] && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!reqReady[k]) begin
      chk($sformatf("accept_timeout[%0d]", k), 32'(reqReady[k]), 32'd1);
      reqValid[k] = 1'b0;
      acc = -1;
      return;
    end
    acc     = cyc;
    e.cause = cause_of(k, rd, wr, sz, a);
    e.exc   = (e.cause != 2'b00);
    e.due   = cyc + (e.exc ? 1 : lat_of(k));
    e.st    = wr && !e.exc;
    e.keep  = e.exc || wr;
    e.a = a; e.d = d; e.sz = sz;
    e.chk = 1'b1; e.dv = 32'h0;
    if (!e.keep && rd) begin
      e.chk = load_val(k, a, sz, sg, v);
      e.dv  = v;
      if (use_lit) begin
        e.chk = 1'b1;
        e.dv  = lit;
      end
    end
    q[k].push_back(e);
    @(negedge clk);
    if (!hold) reqValid[k] = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("reqReady[%0d]", k), 32'(reqReady[k]), 32'(q[k].size() == 0));
        if (respValid[k]) begin
          if (q[k].size() == 0) begin
            chk($sformatf("spurious_resp[%0d]", k), 32'(respValid[k]), 32'd0);
          end else begin
            mon_e = q[k].pop_front();
            chk($sformatf("resp_cycle[%0d]", k), 32'(cyc), 32'(mon_e.due));
            chk($sformatf("exception[%0d]", k), 32'(exception[k]), 32'(mon_e.exc));
            chk($sformatf("excCause[%0d]", k), 32'(excCause[k]), 32'(mon_e.cause));
            if (mon_e.keep) begin
              if (last_known[k]) chk($sformatf("dout_kept[%0d]", k), dout[k], last_dout[k]);
            end else begin
              if (mon_e.chk) chk($sformatf("dout[%0d]", k), dout[k], mon_e.dv);
              last_dout[k]  = mon_e.dv;
              last_known[k] = mon_e.chk;
            end
            if (mon_e.st)
              for (int i = 0; i < nbytes(mon_e.sz); i++)
                ref_mem[key_of(k, mon_e.a + 32'(i))] = mon_e.d[8*i +: 8];
          end
        end else begin
          chk($sformatf("exc_idle[%0d]", k), {29'h0, exception[k], excCause[k]}, 32'h0);
          if (last_known[k]) chk($sformatf("dout_hold[%0d]", k), dout[k], last_dout[k]);
          if (q[k].size() != 0 && cyc > q[k][0].due) begin
            chk($sformatf("resp_missing[%0d]", k), 32'(cyc), 32'(q[k][0].due));
            void'(q[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    int acc, prev, r, w;
    logic rd, wr, sg;
    logic [1:0] sz;
    logic [31:0] a;

    rst = 3'b111; reqValid = 3'b000; memWrite = 3'b000; memRead = 3'b000; memSign = 3'b000;
    for (int k = 0; k < 3; k++) begin
      addr[k] = 32'h0; din[k] = 32'h0; memSize[k] = 2'b00;
      last_dout[k] = 32'h0; last_known[k] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_reqReady[%0d]", k), 32'(reqReady[k]), 32'd1);
      chk($sformatf("rst_respValid[%0d]", k), 32'(respValid[k]), 32'd0);
      chk($sformatf("rst_dout[%0d]", k), dout[k], 32'h0);
      chk($sformatf("rst_exc[%0d]", k), {29'h0, exception[k], excCause[k]}, 32'h0);
    end
    rst = 3'b000;
    @(negedge clk);

    // Store image, then sub-word loads against fixed values
    issue(0, 0, 1, 2'b10, 0, 32'h0, 32'h1234_5678, 0, 0, 0, acc);
    issue(0, 0, 1, 2'b01, 0, 32'h4, 32'h1234_5678, 0, 0, 0, acc);
    issue(0, 0, 1, 2'b00, 0, 32'h6, 32'h0000_00FF, 0, 0, 0, acc);
    issue(0, 0, 1, 2'b00, 0, 32'h7, 32'h0000_00EE, 0, 0, 0, acc);
    issue(0, 1, 0, 2'b10, 0, 32'h4, 0, 0, 1, 32'hEEFF_5678, acc);
    issue(0, 1, 0, 2'b01, 1, 32'h6, 0, 0, 1, 32'hFFFF_EEFF, acc);
    issue(0, 1, 0, 2'b01, 0, 32'h6, 0, 0, 1, 32'h0000_EEFF, acc);
    issue(0, 1, 0, 2'b00, 1, 32'h0, 0, 0, 1, 32'h0000_0078, acc);
    issue(0, 1, 0, 2'b00, 1, 32'h7, 0, 0, 1, 32'hFFFF_FFEE, acc);
    issue(0, 1, 0, 2'b00, 0, 32'h7, 0, 0, 1, 32'h0000_00EE, acc);
    issue(0, 1, 0, 2'b10, 0, 32'h0, 0, 0, 1, 32'h1234_5678, acc);
    // Exceptions and range edges
    issue(0, 1, 0, 2'b10, 0, 32'h3, 0, 0, 0, 0, acc);
    issue(0, 0, 1, 2'b01, 0, 32'h5, 32'hAAAA_BBBB, 0, 0, 0, acc);
    issue(0, 1, 0, 2'b10, 0, 32'h4, 0, 0, 1, 32'hEEFF_5678, acc);
    issue(0, 1, 0, 2'b11, 0, 32'h0, 0, 0, 0, 0, acc);
    issue(0, 1, 1, 2'b10, 0, 32'h0, 32'h1, 0, 0, 0, acc);
    issue(0, 1, 0, 2'b10, 0, 32'h40, 0, 0, 0, 0, acc);
    issue(0, 0, 1, 2'b10, 0, 32'h3C, 32'hA5A5_A5A5, 0, 0, 0, acc);
    issue(0, 1, 0, 2'b10, 0, 32'h3C, 0, 0, 1, 32'hA5A5_A5A5, acc);
    issue(1, 1, 0, 2'b10, 0, 32'h0FFC, 0, 0, 0, 0, acc);
    issue(1, 1, 0, 2'b10, 0, 32'h1040, 0, 0, 0, 0, acc);

    // Fill every word so all later loads have a known reference
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++)
        issue(k, 0, 1, 2'b10, 0, base_of(k) + 32'(4*i), $urandom, 0, 0, 0, acc);
      issue(k, 0, 0, 2'b10, 0, base_of(k), 32'h0, 0, 0, 0, acc);
    end

    // Continuous reqValid: acceptances every LATENCY+1 cycles
    for (int k = 1; k < 3; k++) begin
      prev = -1;
      for (int i = 0; i < 6; i++) begin
        issue(k, 1, 0, 2'b10, 0, base_of(k) + 32'(4*$urandom_range(0, 15)), 0, 1, 0, 0, acc);
        if (prev >= 0) chk($sformatf("spacing[%0d]", k), 32'(acc - prev), 32'(lat_of(k) + 1));
        prev = acc;
      end
      reqValid[k] = 1'b0;
    end

    // Random traffic against the reference model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        r  = int'($urandom % 10);
        rd = (r < 4) || (r == 9);
        wr = (r >= 4 && r < 8) || (r == 9);
        sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
        sg = 1'($urandom);
        a  = base_of(k) + 32'($urandom_range(0, 72));
        if (k == 1 && $urandom % 8 == 0) a = a - 32'd8;
        issue(k, rd, wr, sz, sg, a, $urandom, bit'($urandom % 2), 0, 0, acc);
      end
      reqValid[k] = 1'b0;
      @(negedge clk);
    end

    // Reset while a store is in BUSY: the store must be lost
    issue(2, 0, 1, 2'b10, 0, 32'h8, 32'hDEAD_BEEF, 0, 0, 0, acc);
    @(negedge clk);
    rst[2] = 1'b1;
    q[2].delete();
    last_dout[2] = 32'h0;
    last_known[2] = 1'b1;
    #1;
    chk("busy_rst_reqReady", 32'(reqReady[2]), 32'd1);
    chk("busy_rst_respValid", 32'(respValid[2]), 32'd0);
    chk("busy_rst_dout", dout[2], 32'h0);
    chk("busy_rst_exc", {29'h0, exception[2], excCause[2]}, 32'h0);
    repeat (2) @(negedge clk);
    rst[2] = 1'b0;
    issue(2, 1, 0, 2'b10, 0, 32'h8, 0, 0, 0, 0, acc);
    issue(2, 1, 0, 2'b01, 1, 32'hA, 0, 0, 0, 0, acc);

    w = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 32'(q[0].size() + q[1].size() + q[2].size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_mc.md
Name: data_memory_mc

Overview:
Parametrised, multi-cycle, byte-addressed little-endian data memory for the multi-cycle/pipelined datapath. Successor to the single-cycle data memory. Adds configurable depth and access latency, a valid/ready request handshake with a one-cycle response pulse, and an encoded exception cause (misaligned, out-of-range, illegal op) in place of a single exception bit. Sits between the MEM stage/controller and the backing storage.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; the byte address range is BASE_ADDR to BASE_ADDR+4*DEPTH_WORDS-1.
LATENCY, 2, cycles from request acceptance to the normal response; legal values are 1 to 15.
BASE_ADDR, 32'h0000_0000, byte address of word 0; must be word aligned.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
reqValid  in  1  request present
reqReady  out  1  block can accept a request
addr  in  32  byte address
din  in  32  store data, right-aligned
memWrite  in  1  store request
memRead  in  1  load request
memSize  in  2  00 byte, 01 half, 10 word, 11 illegal
memSign  in  1  sign-extend loaded byte/half; ignored for words and stores
respValid  out  1  one-cycle response pulse
dout  out  32  load result; valid while respValid=1, then held
exception  out  1  response carries an exception; qualified by respValid
excCause  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal op

Behaviour:
- Reset (async, rst=1): state goes to IDLE, reqReady=1, respValid=0, dout=0, exception=0, excCause=00, latency counter=0. Any in-flight store is aborted and never written. Memory contents are not cleared by rst and are undefined after power-up.
- FSM states are IDLE, BUSY, RESP. reqReady=1 only in IDLE.
- Acceptance: a request is accepted on an edge where state=IDLE and reqValid=1. At that edge all inputs (addr, din, memWrite, memRead, memSize, memSign) are latched into registers. Later input changes are ignored until the next acceptance.
- Checks are made on the latched request, in this priority order:
  - memRead=1 and memWrite=1 → cause 11.
  - memSize=11 → cause 11.
  - Misaligned → cause 01. A half is misaligned when addr[0]=1; a word is misaligned when addr[1:0]≠00.
  - Out of range → cause 10. Out of range means addr<BASE_ADDR or (addr-BASE_ADDR)>>2 ≥ DEPTH_WORDS.
  - memRead=0 and memWrite=0 is a NOP. It is not an exception: it gets a normal-latency response with dout=0.
- Exception path: go directly to RESP. respValid=1 in the cycle after acceptance (T+1) with exception=1 and excCause set. No memory write occurs. dout keeps its previous value.
- Normal path: if LATENCY=1, go directly to RESP; otherwise go to BUSY with counter=LATENCY-1. The counter decrements each cycle in BUSY and the FSM moves to RESP when it reaches 1. Result: respValid is asserted in cycle T+LATENCY.
- Store commit: the array is written only on the edge entering RESP. Written lanes are:
  - byte: din[7:0] to lane addr[1:0]
  - half: din[15:0] to lanes {addr[1],0} and {addr[1],1}
  - word: all 4 lanes
  Other lanes are untouched. For a store response, dout keeps its previous value.
- Load: the word is read at the edge entering RESP and the selected lane(s) are loaded into dout. Sub-word loads are sign-extended when memSign=1 and zero-extended when memSign=0.
- RESP lasts exactly one cycle: respValid=1, then state returns to IDLE with respValid=0. The next request can therefore be accepted at the earliest in the cycle after respValid; back-to-back throughput is one access per LATENCY+1 cycles.
- A load issued after a store to the same address returns the stored data (there is never overlap).
- Reset asserted during BUSY or RESP follows the reset rule above; the first request after rst deasserts behaves normally.
- exception and excCause are 0 whenever respValid=0.

Test Plan:
1. LATENCY=2, BASE_ADDR=0. Issue sw 0x0=12345678, sh 0x4=5678 (din 12345678), sb 0x6=FF, sb 0x7=EE → each respValid exactly 2 cycles after acceptance, exception=0. Then lw 0x4 → dout=EEFF5678.
2. On that memory image: lh 0x6 → FFFFEEFF; lhu 0x6 → 0000EEFF; lb 0x0 → 00000078; lb 0x7 → FFFFFFEE; lbu 0x7 → 000000EE; lw 0x0 → 12345678.
3. lw 0x3 → cause 01, respValid at T+1. sh 0x5 → cause 01, and a following lw 0x4 still returns EEFF5678. memSize=11 → cause 11. memRead=memWrite=1 → cause 11.
4. DEPTH_WORDS=16: lw 0x40 → cause 10; sw 0x3C=A5A5A5A5 then lw 0x3C → A5A5A5A5. BASE_ADDR=0x1000: lw 0x0FFC → cause 10.
5. Hold reqValid=1 continuously with LATENCY=1 and then LATENCY=4 → reqReady low outside IDLE, acceptances spaced 2 and 5 cycles apart, no dropped or duplicated responses. NOP request → dout=0, no exception.
6. LATENCY=4: sw 0x8=DEADBEEF, assert rst during BUSY → all outputs reset immediately. After release, lw 0x8 returns the prior contents (not DEADBEEF); the next request completes with normal timing.
